// File: rtl/mmu_pkg.sv
// Shared types and helpers for the systolic-array output path.
// Holds the accumulator FSM states and the saturating adder used under MACC_ACC_SAT_EN.
package mmu_pkg;

   localparam int MACC_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      FINISH
   } macc_accum_state_t;

   // Signed 16-bit add clamped to the representable range.
   function automatic logic [MACC_W-1:0] sat_add(input logic [MACC_W-1:0] a,
                                                 input logic [MACC_W-1:0] b);
      logic [MACC_W:0] s;
      s = {a[MACC_W-1], a} + {b[MACC_W-1], b};
      if (s[MACC_W] != s[MACC_W-1])
         return s[MACC_W] ? 16'h8000 : 16'h7FFF;
      return s[MACC_W-1:0];
   endfunction

endpackage

// File: rtl/macc_accum_col.sv
// One column of the accumulator: result storage, arrival counter and RMW adder.
// MACC_ACC_SAT_EN selects a saturating accumulate; otherwise the adder wraps.
module macc_accum_col
   import mmu_pkg::*;
#(
   parameter int acc_depth = 8,
   parameter int addr_w    = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              collect,
   input  logic              active,
   input  logic [MACC_W-1:0] din,
   input  logic [addr_w-1:0] base_addr,
   input  logic [addr_w:0]   num_vecs,
   input  logic              accumulate,
   input  logic [addr_w-1:0] rd_addr,
   output logic [MACC_W-1:0] rd_word,
   output logic              complete
);

   logic [MACC_W-1:0] mem [acc_depth];
   logic [addr_w:0]   count;
   logic [addr_w:0]   count_nxt;
   logic [addr_w-1:0] row;
   logic [MACC_W-1:0] sum;
   logic [MACC_W-1:0] wr_val;
   logic              take;

   // Beats past num_vecs are dropped so a late skewed column cannot overrun.
   assign take      = collect && active && (count < num_vecs);
   assign row       = base_addr + count[addr_w-1:0];
   assign count_nxt = take ? count + 1'b1 : count;
   assign complete  = (count_nxt == num_vecs);

`ifdef MACC_ACC_SAT_EN
   assign sum = sat_add(mem[row], din);
`else
   assign sum = mem[row] + din;
`endif

   assign wr_val  = accumulate ? sum : din;
   assign rd_word = mem[rd_addr];

   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (take)
         count <= count_nxt;
   end

   // Storage has no reset so results survive an aborted run.
   always_ff @(posedge clk) begin
      if (take)
         mem[row] <= wr_val;
   end

endmodule

// File: rtl/macc_accum.sv
// Output accumulator behind the systolic array: per-column skew-tolerant collection
// into a result buffer with a registered read port. MACC_ACC_SAT_EN enables saturation.
module macc_accum
   import mmu_pkg::*;
#(
   parameter  int width_height = 2,
   parameter  int acc_depth    = 8,
   localparam int addr_w       = $clog2(acc_depth)
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic [addr_w-1:0]              base_addr,
   input  logic [addr_w:0]                num_vecs,
   input  logic                           accumulate,
   input  logic [width_height-1:0]        activein,
   input  logic [MACC_W*width_height-1:0] maccin,
   output logic                           busy,
   output logic                           done,
   input  logic                           rd_en,
   input  logic [addr_w-1:0]              rd_addr,
   output logic [MACC_W*width_height-1:0] rd_data
);

   macc_accum_state_t             state;
   logic [addr_w-1:0]             base_q;
   logic [addr_w:0]               num_q;
   logic                          acc_q;
   logic                          clr;
   logic                          collect;
   logic                          all_complete;
   logic [width_height-1:0]       complete;
   logic [MACC_W*width_height-1:0] rd_mux;

   assign clr          = (state == IDLE) && start;
   assign collect      = (state == COLLECT);
   assign all_complete = &complete;

   for (genvar c = 0; c < width_height; c++) begin : g_col
      logic [MACC_W-1:0] rd_word;

      macc_accum_col #(
         .acc_depth (acc_depth),
         .addr_w    (addr_w)
      ) u_col (
         .clk        (clk),
         .reset      (reset),
         .clr        (clr),
         .collect    (collect),
         .active     (activein[c]),
         .din        (maccin[c*MACC_W +: MACC_W]),
         .base_addr  (base_q),
         .num_vecs   (num_q),
         .accumulate (acc_q),
         .rd_addr    (rd_addr),
         .rd_word    (rd_word),
         .complete   (complete[c])
      );

      assign rd_mux[c*MACC_W +: MACC_W] = rd_word;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         base_q <= '0;
         num_q  <= '0;
         acc_q  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  base_q <= base_addr;
                  num_q  <= num_vecs;
                  acc_q  <= accumulate;
                  busy   <= 1'b1;
                  if (num_vecs == '0) begin
                     state <= FINISH;
                     done  <= 1'b1;
                  end else begin
                     state <= COLLECT;
                  end
               end
            end
            COLLECT: begin
               if (all_complete) begin
                  state <= FINISH;
                  done  <= 1'b1;
               end
            end
            FINISH: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Reads see the buffer before any same-edge write.
   always_ff @(posedge clk) begin
      if (reset)
         rd_data <= '0;
      else if (rd_en)
         rd_data <= rd_mux;
   end

endmodule

// File: tb/tb_macc_accum.sv
// Directed bench for macc_accum: table-driven collection runs plus hand-written
// sequences for zero-length runs, start-while-busy, mid-run reset and read/write collision.
module tb_macc_accum;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  base_addr;
   logic [3:0]  num_vecs;
   logic        accumulate;
   logic [1:0]  activein;
   logic [31:0] maccin;
   logic        busy;
   logic        done;
   logic        rd_en;
   logic [2:0]  rd_addr;
   logic [31:0] rd_data;

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   macc_accum #(.width_height(2), .acc_depth(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .base_addr  (base_addr),
      .num_vecs   (num_vecs),
      .accumulate (accumulate),
      .activein   (activein),
      .maccin     (maccin),
      .busy       (busy),
      .done       (done),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data)
   );

   typedef struct {
      logic [1:0]  act;
      logic [15:0] d0;
      logic [15:0] d1;
      logic        b;
      logic        d;
   } beat_t;

   beat_t beats [13];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic collect(input logic [2:0] b, input logic [3:0] n, input logic a,
                          input int first, input int cnt, input string tag);
      start = 1'b1; base_addr = b; num_vecs = n; accumulate = a;
      tick();
      start = 1'b0;
      for (int i = first; i < first + cnt; i++) begin
         activein = beats[i].act;
         maccin   = {beats[i].d1, beats[i].d0};
         chk($sformatf("%s busy c%0d", tag, i - first + 1), {31'b0, busy}, {31'b0, beats[i].b});
         chk($sformatf("%s done c%0d", tag, i - first + 1), {31'b0, done}, {31'b0, beats[i].d});
         tick();
      end
      activein = '0;
      maccin   = '0;
   endtask

   task automatic rd_check(input logic [2:0] a, input logic [31:0] exp, input string tag);
      rd_en = 1'b1; rd_addr = a;
      tick();
      rd_en = 1'b0; rd_addr = 3'd0;
      chk($sformatf("%s row%0d", tag, a), rd_data, exp);
      tick();
      chk($sformatf("%s row%0d hold", tag, a), rd_data, exp);
   endtask

   initial begin
      // overwrite / accumulate run: col0 at cycles 1-2, col1 at cycles 2-3
      beats[0]  = '{2'b01, 16'd5, 16'd0,  1'b1, 1'b0};
      beats[1]  = '{2'b11, 16'd7, 16'd9,  1'b1, 1'b0};
      beats[2]  = '{2'b10, 16'd0, 16'd11, 1'b1, 1'b0};
      beats[3]  = '{2'b00, 16'd0, 16'd0,  1'b1, 1'b1};
      beats[4]  = '{2'b00, 16'd0, 16'd0,  1'b0, 1'b0};
      // wrap run with a third beat per column
      beats[5]  = '{2'b01, 16'd1, 16'd0, 1'b1, 1'b0};
      beats[6]  = '{2'b11, 16'd2, 16'd1, 1'b1, 1'b0};
      beats[7]  = '{2'b11, 16'd3, 16'd2, 1'b1, 1'b0};
      beats[8]  = '{2'b10, 16'd0, 16'd3, 1'b1, 1'b1};
      beats[9]  = '{2'b00, 16'd0, 16'd0, 1'b0, 1'b0};
      // single-beat runs used for the overflow case
      beats[10] = '{2'b11, 16'h7FFF, 16'h8000, 1'b1, 1'b0};
      beats[11] = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b1};
      beats[12] = '{2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0};

      reset = 1'b1; start = 1'b0; base_addr = '0; num_vecs = '0; accumulate = 1'b0;
      activein = '0; maccin = '0; rd_en = 1'b0; rd_addr = '0;
      tick(); tick();
      reset = 1'b0;
      chk("reset busy", {31'b0, busy}, 32'd0);
      chk("reset done", {31'b0, done}, 32'd0);
      chk("reset rd_data", rd_data, 32'd0);

      collect(3'd0, 4'd2, 1'b0, 0, 5, "ovw");
      rd_check(3'd0, {16'd9, 16'd5}, "ovw");
      rd_check(3'd1, {16'd11, 16'd7}, "ovw");

      collect(3'd0, 4'd2, 1'b1, 0, 5, "acc");
      rd_check(3'd0, {16'd18, 16'd10}, "acc");
      rd_check(3'd1, {16'd22, 16'd14}, "acc");

      collect(3'd7, 4'd2, 1'b0, 5, 5, "wrap");
      rd_check(3'd7, {16'd1, 16'd1}, "wrap");
      rd_check(3'd0, {16'd2, 16'd2}, "wrap");
      rd_check(3'd1, {16'd22, 16'd14}, "wrap");

      collect(3'd2, 4'd1, 1'b0, 10, 3, "ovf_load");
      beats[10].d0 = 16'h0001;
      beats[10].d1 = 16'hFFFF;
      collect(3'd2, 4'd1, 1'b1, 10, 3, "ovf_add");
`ifdef MACC_ACC_SAT_EN
      rd_check(3'd2, {16'h8000, 16'h7FFF}, "ovf");
`else
      rd_check(3'd2, {16'h7FFF, 16'h8000}, "ovf");
`endif

      // zero-length run: done next cycle, beats ignored
      start = 1'b1; base_addr = 3'd2; num_vecs = 4'd0; accumulate = 1'b0;
      tick();
      start = 1'b0;
      chk("nv0 busy", {31'b0, busy}, 32'd1);
      chk("nv0 done", {31'b0, done}, 32'd1);
      activein = 2'b11; maccin = 32'hAAAA_AAAA;
      tick();
      activein = '0; maccin = '0;
      chk("nv0 busy after", {31'b0, busy}, 32'd0);
      chk("nv0 done after", {31'b0, done}, 32'd0);
`ifdef MACC_ACC_SAT_EN
      rd_check(3'd2, {16'h8000, 16'h7FFF}, "nv0");
`else
      rd_check(3'd2, {16'h7FFF, 16'h8000}, "nv0");
`endif

      // start while busy must not alter the run
      start = 1'b1; base_addr = 3'd3; num_vecs = 4'd2; accumulate = 1'b0;
      tick();
      activein = 2'b11; maccin = {16'd20, 16'd10};
      base_addr = 3'd5; num_vecs = 4'd1; accumulate = 1'b1;
      tick();
      start = 1'b0;
      activein = 2'b11; maccin = {16'd40, 16'd30};
      chk("sbusy done c2", {31'b0, done}, 32'd0);
      tick();
      activein = '0; maccin = '0;
      chk("sbusy done c3", {31'b0, done}, 32'd1);
      chk("sbusy busy c3", {31'b0, busy}, 32'd1);
      tick();
      chk("sbusy busy c4", {31'b0, busy}, 32'd0);
      rd_check(3'd3, {16'd20, 16'd10}, "sbusy");
      rd_check(3'd4, {16'd40, 16'd30}, "sbusy");

      // reset after one beat
      start = 1'b1; base_addr = 3'd6; num_vecs = 4'd2; accumulate = 1'b0;
      tick();
      start = 1'b0;
      activein = 2'b11; maccin = {16'h0066, 16'h0055};
      tick();
      activein = '0; maccin = '0; reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst busy", {31'b0, busy}, 32'd0);
      chk("rst done", {31'b0, done}, 32'd0);
      rd_check(3'd6, {16'h0066, 16'h0055}, "rst");
      start = 1'b1; base_addr = 3'd6; num_vecs = 4'd1; accumulate = 1'b1;
      tick();
      start = 1'b0;
      chk("rst restart busy", {31'b0, busy}, 32'd1);
      activein = 2'b11; maccin = {16'd1, 16'd1};
      tick();
      activein = '0; maccin = '0;
      chk("rst restart done", {31'b0, done}, 32'd1);
      tick();
      rd_check(3'd6, {16'h0067, 16'h0056}, "rst restart");

      // read and write of the same row on the same edge
      start = 1'b1; base_addr = 3'd0; num_vecs = 4'd1; accumulate = 1'b0;
      tick();
      start = 1'b0;
      activein = 2'b11; maccin = {16'h0088, 16'h0077};
      rd_en = 1'b1; rd_addr = 3'd0;
      tick();
      activein = '0; maccin = '0; rd_en = 1'b0;
      chk("coll old value", rd_data, {16'd2, 16'd2});
      chk("coll done", {31'b0, done}, 32'd1);
      rd_check(3'd0, {16'h0088, 16'h0077}, "coll new");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
